// File: rtl/mem_latency_responder_pkg.sv
// Shared definitions for the memory latency responder.
// Holds the responder FSM state encoding, the default word size and the
// default memory latency. The CPU controller uses the same latency constant
// so its IF/MEM state counts match the memory's completion timing.
package mem_latency_responder_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int MEM_LATENCY = 3;
    // Wide enough for the largest legal latency (15).
    localparam int CNT_WIDTH   = 4;

    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_BUSY = 2'd1,
        MEMR_HOLD = 2'd2
    } memr_state_t;

    // Counter preload for a request accepted at the sampling edge: the
    // sampling edge itself is the first of the LATENCY edges.
    function automatic logic [CNT_WIDTH-1:0] latency_preload(input int latency);
        return CNT_WIDTH'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_latency_responder_latency_counter.sv
// Loadable down-counter that paces the responder's BUSY state.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears the count
//   load       load load_value (lower priority than clear)
//   load_value value to load
//   enable     decrement by one (saturates at zero)
//   clear      force count to zero (highest priority)
//   terminal   high while the count equals 1 (last wait edge)
module latency_counter
    import mem_latency_responder_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             clear,
    output logic             terminal
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign terminal = (count_reg == WIDTH'(1));

endmodule

// File: rtl/mem_latency_responder.sv
// Memory-side responder for the multi-cycle CPU's shared instruction/data
// port. A read or write request held by the controller is accepted in IDLE,
// waits LATENCY edges in total, then completes with a one-cycle ready pulse.
// A request that drops or changes operation while waiting is aborted.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (storage is not cleared)
//   mem_read    read request, held until ready
//   mem_write   write request, held until ready
//   address     word address; only the low DEPTH_LOG2 bits select a word
//   write_data  store data
//   read_data   load/fetch data, valid while ready is high, held afterwards
//   ready       one-cycle completion pulse
//   busy        request accepted and not yet completed
//   req_error   one-cycle pulse on simultaneous read and write request
module mem_latency_responder
    import mem_latency_responder_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_SIZE,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = MEM_LATENCY   // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  req_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    memr_state_t           state_reg, state_next;
    logic [DEPTH_LOG2-1:0] addr_reg;
    logic [WORD_WIDTH-1:0] data_reg;
    logic                  op_write_reg;
    logic [WORD_WIDTH-1:0] read_data_reg;
    logic                  ready_reg, ready_next;
    logic                  busy_reg, busy_next;
    logic                  req_error_reg, req_error_next;

    logic                  latch_req;
    logic                  complete;
    logic                  cnt_load, cnt_enable, cnt_clear, cnt_terminal;
    logic                  single_req;
    logic                  op_held;
    logic                  cur_write;
    logic [DEPTH_LOG2-1:0] cur_addr;
    logic [WORD_WIDTH-1:0] cur_data;

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_wrap
            // Upper address bits are deliberately dropped: addresses wrap.
            logic unused_addr_bits;
            assign unused_addr_bits = ^address[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    assign single_req = mem_read ^ mem_write;
    // The accepted operation is still requested, and nothing else is.
    assign op_held = op_write_reg ? (mem_write & ~mem_read)
                                  : (mem_read & ~mem_write);

    // With LATENCY=1 completion happens at the accepting edge in IDLE, before
    // anything is latched, so the live inputs are the completion source there.
    assign cur_write = (state_reg == MEMR_IDLE) ? mem_write : op_write_reg;
    assign cur_addr  = (state_reg == MEMR_IDLE) ? address[DEPTH_LOG2-1:0] : addr_reg;
    assign cur_data  = (state_reg == MEMR_IDLE) ? write_data : data_reg;

    latency_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_latency_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (latency_preload(LATENCY)),
        .enable     (cnt_enable),
        .clear      (cnt_clear),
        .terminal   (cnt_terminal)
    );

    always_comb begin
        state_next     = state_reg;
        ready_next     = 1'b0;
        busy_next      = 1'b0;
        req_error_next = 1'b0;
        latch_req      = 1'b0;
        complete       = 1'b0;
        cnt_load       = 1'b0;
        cnt_enable     = 1'b0;
        cnt_clear      = 1'b0;
        case (state_reg)
            MEMR_IDLE: begin
                if (single_req) begin
                    latch_req = 1'b1;
                    if (LATENCY == 1) begin
                        complete   = 1'b1;
                        state_next = MEMR_HOLD;
                    end else begin
                        cnt_load   = 1'b1;
                        busy_next  = 1'b1;
                        state_next = MEMR_BUSY;
                    end
                end else if (mem_read && mem_write) begin
                    req_error_next = 1'b1;
                end
            end
            MEMR_BUSY: begin
                if (!op_held) begin
                    cnt_clear  = 1'b1;
                    state_next = MEMR_IDLE;
                end else if (cnt_terminal) begin
                    complete   = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = MEMR_HOLD;
                end else begin
                    cnt_enable = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            MEMR_HOLD: begin
                // A request still held after completion must not re-trigger.
                if (!(mem_read || mem_write)) begin
                    state_next = MEMR_IDLE;
                end
            end
            default: begin
                state_next = MEMR_IDLE;
            end
        endcase
        ready_next = complete;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= MEMR_IDLE;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            req_error_reg <= 1'b0;
            read_data_reg <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            op_write_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            req_error_reg <= req_error_next;
            if (latch_req) begin
                addr_reg     <= address[DEPTH_LOG2-1:0];
                data_reg     <= write_data;
                op_write_reg <= mem_write;
            end
            if (complete) begin
                read_data_reg <= cur_write ? cur_data : mem[cur_addr];
            end
        end
    end

    // Storage is never reset; a reset edge must not commit a pending write.
    always_ff @(posedge clk) begin
        if (complete && cur_write && !reset) begin
            mem[cur_addr] <= cur_data;
        end
    end

    assign read_data = read_data_reg;
    assign ready     = ready_reg;
    assign busy      = busy_reg;
    assign req_error = req_error_reg;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Bench for mem_latency_responder: one instance with the default latency (3)
// and one with LATENCY=1. Expected behaviour comes from a transaction-level
// model: a word array per instance plus the rule that a request held for
// `hold` sampling edges completes iff hold >= LATENCY, with ready in cycle
// LATENCY after the sampling edge and busy in cycles 1..min(hold, LATENCY-1).
module tb_mem_latency_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic [15:0] rdata0, rdata1;
    logic        ready0, ready1, busy0, busy1, err0, err1;

    int total = 0;
    int bad   = 0;

    logic [15:0] ref0 [256];
    logic [15:0] ref1 [256];
    logic [15:0] exp_rd0 = '0;
    logic [15:0] exp_rd1 = '0;

    always #5 clk = ~clk;

    mem_latency_responder #(
        .WORD_WIDTH (16), .ADDR_WIDTH (16), .DEPTH_LOG2 (8), .LATENCY (3)
    ) dut0 (
        .clk (clk), .reset (reset), .mem_read (rd0), .mem_write (wr0),
        .address (addr0), .write_data (wd0), .read_data (rdata0),
        .ready (ready0), .busy (busy0), .req_error (err0)
    );

    mem_latency_responder #(
        .WORD_WIDTH (16), .ADDR_WIDTH (16), .DEPTH_LOG2 (8), .LATENCY (1)
    ) dut1 (
        .clk (clk), .reset (reset), .mem_read (rd1), .mem_write (wr1),
        .address (addr1), .write_data (wd1), .read_data (rdata1),
        .ready (ready1), .busy (busy1), .req_error (err1)
    );

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            rd0 = r; wr0 = w; addr0 = a; wd0 = d;
        end else begin
            rd1 = r; wr1 = w; addr1 = a; wd1 = d;
        end
    endtask

    task automatic sample(input int sel, output logic r, output logic b,
                          output logic e, output logic [15:0] d);
        r = (sel == 0) ? ready0 : ready1;
        b = (sel == 0) ? busy0  : busy1;
        e = (sel == 0) ? err0   : err1;
        d = (sel == 0) ? rdata0 : rdata1;
    endtask

    // One request held for `hold` sampling edges, then dropped. Address and
    // data are scrambled while the request is held to show latching.
    task automatic do_request(input int sel, input bit is_write,
                              input logic [15:0] addr, input logic [15:0] data,
                              input int hold, input string tag);
        int          lat, kmax, busy_last;
        bit          complete;
        logic [7:0]  idx;
        logic [15:0] prev_rd, new_rd, want_rd;
        logic        o_r, o_b, o_e;
        logic [15:0] o_d;
        lat       = (sel == 0) ? 3 : 1;
        complete  = (hold >= lat);
        idx       = addr[7:0];
        prev_rd   = (sel == 0) ? exp_rd0 : exp_rd1;
        new_rd    = is_write ? data : ((sel == 0) ? ref0[idx] : ref1[idx]);
        busy_last = (hold < lat - 1) ? hold : lat - 1;
        kmax      = ((hold > lat) ? hold : lat) + 2;
        drive(sel, !is_write, is_write, addr, data);
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            sample(sel, o_r, o_b, o_e, o_d);
            total++;
            if (o_r !== (complete && k == lat)) begin
                bad++;
                $display("FAIL %s ready dut%0d k=%0d got=%b want=%b", tag, sel, k, o_r, complete && k == lat);
            end
            total++;
            if (o_b !== (k <= busy_last)) begin
                bad++;
                $display("FAIL %s busy dut%0d k=%0d got=%b want=%b", tag, sel, k, o_b, k <= busy_last);
            end
            total++;
            if (o_e !== 1'b0) begin
                bad++;
                $display("FAIL %s req_error dut%0d k=%0d got=%b want=0", tag, sel, k, o_e);
            end
            want_rd = (complete && k >= lat) ? new_rd : prev_rd;
            total++;
            if (o_d !== want_rd) begin
                bad++;
                $display("FAIL %s read_data dut%0d k=%0d got=%h want=%h", tag, sel, k, o_d, want_rd);
            end
            if (k == hold)
                drive(sel, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
            else if (k < hold)
                drive(sel, !is_write, is_write, 16'($urandom), 16'($urandom));
        end
        if (complete) begin
            if (sel == 0) begin
                exp_rd0 = new_rd;
                if (is_write) ref0[idx] = data;
            end else begin
                exp_rd1 = new_rd;
                if (is_write) ref1[idx] = data;
            end
        end
        $display("[%0t] dut%0d %-14s %s addr=%h data=%h hold=%0d %s", $time, sel, tag,
                 is_write ? "WR" : "RD", addr, new_rd, hold, complete ? "done" : "aborted");
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ready0, busy0, err0, ready1, busy1, err1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000", {ready0, busy0, err0, ready1, busy1, err1});
        end
        total++;
        if (rdata0 !== 16'h0) begin
            bad++;
            $display("FAIL reset_rdata0 got=%h want=0000", rdata0);
        end
        total++;
        if (rdata1 !== 16'h0) begin
            bad++;
            $display("FAIL reset_rdata1 got=%h want=0000", rdata1);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        $display("[%0t] reset released", $time);
    endtask

    task automatic test_init();
        for (int i = 0; i < 256; i++) do_request(0, 1'b1, 16'(i), 16'($urandom), 3, "init");
        for (int i = 0; i < 256; i++) do_request(1, 1'b1, 16'(i), 16'($urandom), 1, "init");
    endtask

    task automatic test_write_read();
        do_request(0, 1'b1, 16'h0005, 16'h1234, 3, "write");
        do_request(0, 1'b0, 16'h0005, 16'h0000, 3, "read_back");
        total++;
        if (rdata0 !== 16'h1234) begin
            bad++;
            $display("FAIL write_read got=%h want=1234", rdata0);
        end
    endtask

    task automatic test_held_request();
        do_request(0, 1'b0, 16'h0002, 16'h0000, 6, "held_read");
    endtask

    task automatic test_abort();
        logic [15:0] old;
        old = ref0[8'h07];
        do_request(0, 1'b1, 16'h0007, 16'hAAAA, 1, "abort_write");
        do_request(0, 1'b0, 16'h0007, 16'h0000, 3, "abort_check");
        total++;
        if (rdata0 !== old) begin
            bad++;
            $display("FAIL abort_readback got=%h want=%h", rdata0, old);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] a;
        a = 8'($urandom);
        drive(0, 1'b1, 1'b1, {8'h00, a}, ~ref0[a]);
        @(posedge clk); #1;
        total++;
        if ({err0, busy0, ready0} !== 3'b100) begin
            bad++;
            $display("FAIL illegal_pulse got=%b want=100", {err0, busy0, ready0});
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        total++;
        if ({err0, busy0, ready0} !== 3'b000) begin
            bad++;
            $display("FAIL illegal_clear got=%b want=000", {err0, busy0, ready0});
        end
        $display("[%0t] dut0 illegal        RD+WR addr=%h", $time, a);
        do_request(0, 1'b0, {8'h00, a}, 16'h0000, 3, "illegal_check");
    endtask

    task automatic test_reset_mid();
        do_request(0, 1'b1, 16'h0010, 16'h1111, 3, "pre_write");
        drive(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        @(posedge clk); #1;
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL midreset_busy got=%b want=1", busy0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++;
        if ({ready0, busy0, err0} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_during got=%b want=000", {ready0, busy0, err0});
        end
        @(posedge clk); #1;
        total++;
        if ({ready0, busy0, err0, rdata0} !== 19'h0) begin
            bad++;
            $display("FAIL midreset_edge got=%b/%h want=000/0000", {ready0, busy0, err0}, rdata0);
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        @(posedge clk); #1;
        total++;
        if ({ready0, busy0, err0} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_after got=%b want=000", {ready0, busy0, err0});
        end
        $display("[%0t] dut0 reset_mid     WR addr=0010 data=beef aborted by reset", $time);
        do_request(0, 1'b0, 16'h0010, 16'h0000, 3, "midreset_chk");
        total++;
        if (rdata0 === 16'hBEEF) begin
            bad++;
            $display("FAIL midreset_commit got=%h want=not beef", rdata0);
        end
    endtask

    task automatic test_wrap_latency1();
        do_request(1, 1'b1, 16'h0101, 16'h00FF, 1, "wrap_write");
        do_request(1, 1'b0, 16'h0001, 16'h0000, 1, "wrap_read");
        total++;
        if (rdata1 !== 16'h00FF) begin
            bad++;
            $display("FAIL wrap_read got=%h want=00ff", rdata1);
        end
        do_request(1, 1'b0, 16'h0001, 16'h0000, 4, "wrap_held");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_request(0, 1'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(1, 6)), "random");
        end
        for (int i = 0; i < 20; i++) begin
            do_request(1, 1'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(1, 4)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_held_request();
        test_abort();
        test_illegal();
        test_reset_mid();
        test_wrap_latency1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
